// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encodings and default widths for the data-memory arbiter
package dmem_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_t;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/upg_wr_buf.sv
// upg_wr_buf: one-entry loader write buffer with push/pop and sticky overflow on a dropped push
module upg_wr_buf #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              ovf
);
  logic load;
  assign load = push && (!valid || pop);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      ovf   <= 1'b0;
    end else begin
      valid <= load || (valid && !pop);
      if (load) begin
        addr <= push_addr;
        data <= push_data;
      end
      if (push && valid && !pop) ovf <= 1'b1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between MEM-stage loads/stores and the UART loader
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              upg_active,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              upg_wen,
  input  logic [ADDR_W-1:0] upg_addr,
  input  logic [DATA_W-1:0] upg_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              upg_ovf
);
  localparam int CW = $clog2(RD_LAT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic idle, rd_wait, rd_done, drain, live_wr, wr_go, cpu_go, st_go, ld_go;
  assign idle    = state == ST_IDLE;
  assign rd_wait = state == ST_RD_WAIT;
  assign rd_done = rd_wait && cnt == '0;
  assign drain   = idle && buf_valid;
  assign live_wr = idle && !buf_valid && upg_wen;
  assign wr_go   = drain || live_wr;
  assign cpu_go  = idle && !wr_go && !upg_active;
  assign st_go   = cpu_go && cpu_wr;
  assign ld_go   = cpu_go && cpu_rd && !cpu_wr;
  assign cpu_stall = rstn && (ld_go || rd_wait || (idle && (cpu_rd || cpu_wr) && (wr_go || upg_active)));
  assign mem_en    = rstn && (wr_go || st_go || ld_go);
  assign mem_we    = rstn && (wr_go || st_go);
  assign mem_addr  = !rstn ? '0 : drain ? buf_addr : live_wr ? upg_addr : (st_go || ld_go) ? cpu_addr : '0;
  assign mem_wdata = !rstn ? '0 : drain ? buf_data : live_wr ? upg_wdata : st_go ? cpu_wdata : '0;
  upg_wr_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
    .clk(clk),
    .rstn(rstn),
    .push(upg_wen && !live_wr),
    .pop(drain),
    .push_addr(upg_addr),
    .push_data(upg_wdata),
    .valid(buf_valid),
    .addr(buf_addr),
    .data(buf_data),
    .ovf(upg_ovf)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cpu_rdata <= '0;
    end else begin
      state <= ld_go ? ST_RD_WAIT : rd_done ? ST_RESP : state == ST_RESP ? ST_IDLE : state;
      cnt   <= ld_go ? CW'(RD_LAT - 1) : (rd_wait && cnt != '0) ? cnt - CW'(1) : cnt;
      if (rd_done) cpu_rdata <= mem_rdata;
    end
endmodule
